rdn_in_buffer: RTL and testbench

//  Two-slot subimage buffer between the histogram equalization unit (HEU) and the rotation detection network (RDN).

---
 rtl/heu_pkg.sv | 22 ++
 rtl/rdn_in_buffer_if.sv | 24 ++
 rtl/rdn_in_slot.sv | 35 +++
 rtl/rdn_in_buffer.sv | 78 +++++++
 tb/tb_rdn_in_buffer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/heu_pkg.sv
// Shared pixel/subimage types and geometry between the HEU and the RDN input buffer.
package heu_pkg;

  localparam int HEU_ROWS  = 5;   // row groups per HEU output word
  localparam int HEU_COLS  = 80;  // bytes per row group (4 image rows of 20 pixels)
  localparam int RDN_BEAT  = 20;  // pixels per output beat (one image row)
  localparam int RDN_BEATS = 20;  // beats per subimage

  typedef logic [7:0] pixel_t;
  typedef pixel_t [HEU_ROWS-1:0][HEU_COLS-1:0] subimage_t;
  typedef pixel_t [RDN_BEAT-1:0] beat_t;
  typedef logic [4:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(RDN_BEATS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/rdn_in_buffer_if.sv
// HEU-side subimage handshake and RDN-side beat stream of the RDN input buffer.
interface rdn_in_buffer_if;
  import heu_pkg::*;

  logic      heu_out_ready;
  subimage_t d;
  logic      in_ready;
  logic      rdn_in_ready;
  logic      out_ready;
  logic      sof;
  logic      eof;
  beat_t     q;

  modport master (
    output heu_out_ready, d, rdn_in_ready,
    input  in_ready, out_ready, sof, eof, q
  );

  modport slave (
    input  heu_out_ready, d, rdn_in_ready,
    output in_ready, out_ready, sof, eof, q
  );

endinterface

// File: rtl/rdn_in_slot.sv
// One subimage slot: whole-array write, beat-select read of one 20-pixel image row.
module rdn_in_slot
  import heu_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  subimage_t d,
  input  beat_idx_t beat,
  output beat_t     q
);

  subimage_t  mem;
  logic [2:0] row;
  logic [6:0] base;

  // NOTE: pixel storage has no reset; the occupancy FSM guarantees a slot is
  // only read after it was written, and the output mux zeroes q when idle.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we) mem <= d;
  end

  // Beat b lives in row group b/4, starting at column (b%4)*20.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q    = '0;
    row  = beat[4:2];
    base = 7'(RDN_BEAT) * 7'(beat[1:0]);
    for (int k = 0; k < RDN_BEAT; k++) begin
      q[k] = mem[row][base + 7'(k)];
    end
  end

endmodule

// File: rtl/rdn_in_buffer.sv
// Two-slot subimage buffer between HEU and RDN; RDN_IN_CENTER_EN makes output pixels signed (p-128).
module rdn_in_buffer
  import heu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rdn_in_buffer_if.slave   bus
);

  occ_e      state, state_nxt;
  logic      wr_ptr, rd_ptr;
  beat_idx_t beat;
  logic      in_ready, out_ready;
  logic      wr_en, pop, last_pop;
  beat_t     q0, q1, raw, pix;

  // Handshake readiness depends only on registered occupancy (and reset).
  assign in_ready  = !rst && (state != FULL);
  assign out_ready = !rst && (state != EMPTY);
  assign wr_en     = bus.heu_out_ready && in_ready;
  assign pop       = out_ready && bus.rdn_in_ready;
  assign last_pop  = pop && (beat == LAST_BEAT);

  rdn_in_slot u_slot0 (.clk(clk), .we(wr_en && !wr_ptr), .d(bus.d), .beat(beat), .q(q0));
  rdn_in_slot u_slot1 (.clk(clk), .we(wr_en &&  wr_ptr), .d(bus.d), .beat(beat), .q(q1));

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (wr_en) state_nxt = ONE;
      ONE: begin
        if (wr_en && !last_pop)      state_nxt = FULL;
        else if (!wr_en && last_pop) state_nxt = EMPTY;
      end
      FULL:    if (last_pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      beat   <= '0;
    end else begin
      if (wr_en)    wr_ptr <= ~wr_ptr;
      if (last_pop) rd_ptr <= ~rd_ptr;
      if (pop)      beat   <= last_pop ? '0 : beat + 5'd1;
    end
  end

  // Centering lives on the read path only; slots always hold raw HEU bytes.
  always_comb begin
    raw = rd_ptr ? q1 : q0;
    pix = '0;
    if (out_ready) begin
      for (int k = 0; k < RDN_BEAT; k++) begin
`ifdef RDN_IN_CENTER_EN
        pix[k] = raw[k] ^ 8'h80;
`else
        pix[k] = raw[k];
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_ready = out_ready;
  assign bus.sof       = out_ready && (beat == '0);
  assign bus.eof       = out_ready && (beat == LAST_BEAT);
  assign bus.q         = pix;

endmodule

// File: tb/tb_rdn_in_buffer.sv
// Scoreboard bench for rdn_in_buffer; expected beats are queued at write time and popped as beats leave.
module tb_rdn_in_buffer;
  import heu_pkg::*;

  typedef struct packed {
    logic  sof;
    logic  eof;
    beat_t pix;
  } beat_rec_t;

  logic clk = 1'b0;
  logic rst;
  rdn_in_buffer_if bus ();

  rdn_in_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int        n_pass  = 0;
  int        n_total = 0;
  beat_rec_t sb[$];

  function automatic pixel_t model_pix(pixel_t p);
`ifdef RDN_IN_CENTER_EN
    return p - 8'd128;
`else
    return p;
`endif
  endfunction

  function automatic beat_rec_t model_beat(subimage_t img, int b);
    beat_rec_t r;
    r.sof = (b == 0);
    r.eof = (b == RDN_BEATS - 1);
    for (int k = 0; k < RDN_BEAT; k++) r.pix[k] = model_pix(img[b / 4][(b % 4) * RDN_BEAT + k]);
    return r;
  endfunction

  function automatic subimage_t make_img(int seed);
    subimage_t img;
    for (int r = 0; r < HEU_ROWS; r++)
      for (int c = 0; c < HEU_COLS; c++)
        img[r][c] = pixel_t'((r * HEU_COLS + c + seed) % 256);
    return img;
  endfunction

  task automatic push_img(subimage_t img);
    for (int b = 0; b < RDN_BEATS; b++) sb.push_back(model_beat(img, b));
  endtask

  function automatic beat_rec_t observe();
    return {bus.sof, bus.eof, bus.q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.heu_out_ready = 1'b0;
    bus.d = '0;
    bus.rdn_in_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.in_ready, bus.out_ready, observe()} !== '0)
      $display("FAIL reset_active: got %h want 0", {bus.in_ready, bus.out_ready, observe()});
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.in_ready, bus.out_ready, observe()} !== {2'b10, 162'd0})
      $display("FAIL reset_release: in_ready=%b out_ready=%b want 1/0", bus.in_ready, bus.out_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_single();
    subimage_t img = make_img(0);
    beat_rec_t exp;
    bus.rdn_in_ready = 1'b1;
    bus.d = img;
    bus.heu_out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    push_img(img);
    tick();
    bus.heu_out_ready = 1'b0;
    for (int b = 0; b < RDN_BEATS; b++) begin
      @(negedge clk);
      exp = sb.pop_front();
      n_total++;
      if ({bus.out_ready, observe()} !== {1'b1, exp})
        $display("FAIL single_beat%0d: got %b/%h want 1/%h", b, bus.out_ready, observe(), exp);
      else n_pass++;
      if (b == 5) begin
        n_total++;
        if (bus.q[0] !== model_pix(8'd100)) $display("FAIL single_b5_lane0: got %h want %h", bus.q[0], model_pix(8'd100));
        else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_total++;
    if ({bus.out_ready, observe()} !== '0) $display("FAIL single_idle: got %b/%h want 0", bus.out_ready, observe());
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    subimage_t img_a = make_img(37);
    subimage_t img_b = make_img(101);
    beat_rec_t exp;
    bus.rdn_in_ready = 1'b0;
    bus.d = img_a;
    bus.heu_out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL b2b_wr_a: in_ready=%b want 1", bus.in_ready);
    else n_pass++;
    push_img(img_a);
    tick();
    bus.d = img_b;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL b2b_wr_b: in_ready=%b want 1", bus.in_ready);
    else n_pass++;
    push_img(img_b);
    tick();
    bus.heu_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.in_ready, bus.out_ready, observe()} !== {2'b01, sb[0]})
        $display("FAIL b2b_hold%0d: got %b%b/%h want 01/%h", i, bus.in_ready, bus.out_ready, observe(), sb[0]);
      else n_pass++;
      tick();
    end
    bus.rdn_in_ready = 1'b1;
    for (int b = 0; b < 2 * RDN_BEATS; b++) begin
      @(negedge clk);
      exp = sb.pop_front();
      n_total++;
      if ({bus.out_ready, observe()} !== {1'b1, exp})
        $display("FAIL b2b_beat%0d: got %b/%h want 1/%h", b, bus.out_ready, observe(), exp);
      else n_pass++;
      if (b == RDN_BEATS - 1 || b == RDN_BEATS) begin
        n_total++;
        if (bus.in_ready !== (b == RDN_BEATS))
          $display("FAIL b2b_in_ready_beat%0d: got %b want %b", b, bus.in_ready, b == RDN_BEATS);
        else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_total++;
    if (bus.out_ready !== 1'b0) $display("FAIL b2b_idle: out_ready=%b want 0", bus.out_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_on_last_pop();
    subimage_t img_a = make_img(5);
    subimage_t img_b = make_img(211);
    beat_rec_t exp;
    bus.rdn_in_ready = 1'b1;
    bus.d = img_a;
    bus.heu_out_ready = 1'b1;
    @(negedge clk);
    push_img(img_a);
    tick();
    bus.heu_out_ready = 1'b0;
    for (int b = 0; b < 2 * RDN_BEATS; b++) begin
      if (b == RDN_BEATS - 1) begin
        bus.d = img_b;
        bus.heu_out_ready = 1'b1;
      end
      @(negedge clk);
      exp = sb.pop_front();
      n_total++;
      if ({bus.out_ready, observe()} !== {1'b1, exp})
        $display("FAIL coincide_beat%0d: got %b/%h want 1/%h", b, bus.out_ready, observe(), exp);
      else n_pass++;
      if (b == RDN_BEATS - 1 || b == RDN_BEATS) begin
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL coincide_in_ready_beat%0d: got %b want 1", b, bus.in_ready);
        else n_pass++;
      end
      if (b == RDN_BEATS - 1) push_img(img_b);
      tick();
      bus.heu_out_ready = 1'b0;
    end
    @(negedge clk);
    n_total++;
    if (bus.out_ready !== 1'b0) $display("FAIL coincide_idle: out_ready=%b want 0", bus.out_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_random_stall();
    int written = 0;
    int cycles  = 0;
    while ((written < 4 || sb.size() != 0) && cycles < 800) begin
      bus.rdn_in_ready  = 1'($urandom_range(0, 1));
      bus.heu_out_ready = (written < 4) && 1'($urandom_range(0, 1));
      bus.d = make_img(300 + written * 13);
      @(negedge clk);
      n_total++;
      if (bus.out_ready !== (sb.size() != 0)) begin
        $display("FAIL rand_valid_cyc%0d: out_ready=%b want %b", cycles, bus.out_ready, sb.size() != 0);
      end else if (bus.out_ready && observe() !== sb[0]) begin
        $display("FAIL rand_beat_cyc%0d: got %h want %h", cycles, observe(), sb[0]);
      end else n_pass++;
      if (bus.out_ready && bus.rdn_in_ready && sb.size() != 0) void'(sb.pop_front());
      if (bus.heu_out_ready && bus.in_ready) begin
        push_img(bus.d);
        written++;
      end
      tick();
      cycles++;
    end
    bus.heu_out_ready = 1'b0;
    n_total++;
    if (written != 4 || sb.size() != 0)
      $display("FAIL rand_timeout: written=%0d pending=%0d want 4/0", written, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    subimage_t img_a = make_img(17);
    subimage_t img_b = make_img(90);
    subimage_t img_c = make_img(150);
    beat_rec_t exp;
    bus.rdn_in_ready = 1'b0;
    bus.d = img_a;
    bus.heu_out_ready = 1'b1;
    @(negedge clk);
    push_img(img_a);
    tick();
    bus.d = img_b;
    @(negedge clk);
    push_img(img_b);
    tick();
    bus.heu_out_ready = 1'b0;
    bus.rdn_in_ready = 1'b1;
    for (int b = 0; b <= 10; b++) begin
      @(negedge clk);
      exp = sb.pop_front();
      n_total++;
      if ({bus.in_ready, bus.out_ready, observe()} !== {2'b01, exp})
        $display("FAIL rstmid_beat%0d: got %b%b/%h want 01/%h", b, bus.in_ready, bus.out_ready, observe(), exp);
      else n_pass++;
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({bus.in_ready, bus.out_ready} !== 2'b00)
      $display("FAIL rstmid_during: in/out=%b%b want 00", bus.in_ready, bus.out_ready);
    else n_pass++;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_total++;
    if ({bus.in_ready, bus.out_ready, observe()} !== {2'b10, 162'd0})
      $display("FAIL rstmid_after: in/out=%b%b q=%h want 10/0", bus.in_ready, bus.out_ready, observe());
    else n_pass++;
    tick();
    bus.d = img_c;
    bus.heu_out_ready = 1'b1;
    @(negedge clk);
    push_img(img_c);
    tick();
    bus.heu_out_ready = 1'b0;
    for (int b = 0; b < RDN_BEATS; b++) begin
      @(negedge clk);
      exp = sb.pop_front();
      n_total++;
      if ({bus.out_ready, observe()} !== {1'b1, exp})
        $display("FAIL rstmid_new_beat%0d: got %b/%h want 1/%h", b, bus.out_ready, observe(), exp);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_center();
    subimage_t  img = make_img(9);
    beat_rec_t  exp;
    logic [31:0] exp_lanes;
`ifdef RDN_IN_CENTER_EN
    exp_lanes = {8'h7F, 8'h00, 8'hFF, 8'h80};
`else
    exp_lanes = {8'hFF, 8'h80, 8'h7F, 8'h00};
`endif
    img[0][0] = 8'h00;
    img[0][1] = 8'h7F;
    img[0][2] = 8'h80;
    img[0][3] = 8'hFF;
    bus.rdn_in_ready = 1'b1;
    bus.d = img;
    bus.heu_out_ready = 1'b1;
    @(negedge clk);
    push_img(img);
    tick();
    bus.heu_out_ready = 1'b0;
    for (int b = 0; b < RDN_BEATS; b++) begin
      @(negedge clk);
      exp = sb.pop_front();
      if (b == 0) begin
        n_total++;
        if (bus.q[3:0] !== exp_lanes) $display("FAIL center_lanes: got %h want %h", bus.q[3:0], exp_lanes);
        else n_pass++;
      end
      n_total++;
      if ({bus.out_ready, observe()} !== {1'b1, exp})
        $display("FAIL center_beat%0d: got %b/%h want 1/%h", b, bus.out_ready, observe(), exp);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_write_on_last_pop();
    test_random_stall();
    test_reset_mid();
    test_center();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
